// File: rtl/uart_tx_sched_if.sv
// Byte-producer handshake plus transmitter hookup for the UART TX scheduler.
interface uart_tx_sched_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]   req_valid;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   req_ready;
   logic              tx_start;
   logic [7:0]        tx_data;
   logic              tx_busy;
   logic [2:0]        grant_id;
   logic              sched_busy;
   logic              timeout_err;

   // Requesters and transmitter side (drives requests and busy)
   modport master (
      output req_valid, req_data, tx_busy,
      input  req_ready, tx_start, tx_data, grant_id, sched_busy, timeout_err
   );

   // Scheduler side
   modport slave (
      input  req_valid, req_data, tx_busy,
      output req_ready, tx_start, tx_data, grant_id, sched_busy, timeout_err
   );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one async_transmitter between NREQ byte
// producers. One byte is accepted per frame; the block then pulses tx_start
// and follows tx_busy until the frame completes before granting again.
module uart_tx_sched #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 16
) (
   input  logic           clk,
   input  logic           clr,
   uart_tx_sched_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] last_q, last_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] tx_data_q, tx_data_d;
   logic [2:0] grant_id_q, grant_id_d;
   logic       timeout_err_q, timeout_err_d;

   logic [7:0]  valid8;
   logic [63:0] data64;
   logic [7:0]  ready8;
   logic        found;
   logic [2:0]  win_idx;
   logic [2:0]  cand;

   // Requests are widened to eight lanes so a 3-bit index is always exact.
   assign valid8 = 8'(bus.req_valid);
   assign data64 = 64'(bus.req_data);

   // Round-robin pick: first valid requester after the previous winner, wrapping.
   always_comb begin
      found   = 1'b0;
      win_idx = '0;
      cand    = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = 3'((int'(last_q) + 1 + k) % NREQ);
         if (!found && valid8[cand]) begin
            found   = 1'b1;
            win_idx = cand;
         end
      end
   end

   // Next-state and accept logic; acceptance is held off during clr so no byte is lost.
   always_comb begin
      state_d       = state_q;
      last_d        = last_q;
      cnt_d         = cnt_q;
      tx_data_d     = tx_data_q;
      grant_id_d    = grant_id_q;
      timeout_err_d = timeout_err_q;
      ready8        = '0;
      case (state_q)
         IDLE: begin
            if (!clr && !bus.tx_busy && found) begin
               ready8[win_idx] = 1'b1;
               tx_data_d       = data64[{win_idx, 3'b000} +: 8];
               grant_id_d      = win_idx;
               last_d          = win_idx;
               state_d         = START;
            end
         end
         START: begin
            cnt_d   = '0;
            state_d = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (bus.tx_busy) begin
               state_d = WAIT_DONE;
            end else begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_d == 8'(TIMEOUT - 1)) begin
                  timeout_err_d = 1'b1;
                  state_d       = IDLE;
               end
            end
         end
         WAIT_DONE: begin
            if (!bus.tx_busy) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; last resets to NREQ-1 so requester 0 wins first.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q       <= IDLE;
         last_q        <= 3'(NREQ - 1);
         cnt_q         <= '0;
         tx_data_q     <= '0;
         grant_id_q    <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_q        <= last_d;
         cnt_q         <= cnt_d;
         tx_data_q     <= tx_data_d;
         grant_id_q    <= grant_id_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign bus.req_ready   = ready8[NREQ-1:0];
   assign bus.tx_start    = (state_q == START);
   assign bus.tx_data     = tx_data_q;
   assign bus.grant_id    = grant_id_q;
   assign bus.sched_busy  = (state_q != IDLE);
   assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: directed scenarios plus randomized
// rounds compared against a round-robin reference model and a simple
// transmitter stand-in whose busy time is chosen by the bench.
module tb_uart_tx_sched;
   localparam int NREQ    = 4;
   localparam int TIMEOUT = 16;

   logic clk        = 1'b0;
   logic clr        = 1'b1;
   logic model_en   = 1'b1;
   logic force_busy = 1'b0;
   int   busy_len   = 20;
   int   xmit_cnt   = 0;
   int   cyc        = 0;
   int   n_checks   = 0;
   int   n_pass     = 0;
   int   exp_last   = NREQ - 1;

   uart_tx_sched_if #(.NREQ(NREQ)) bus ();

   uart_tx_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Cycle counter used to time accepts and starts.
   always @(posedge clk) cyc <= cyc + 1;

   // Transmitter stand-in: busy for busy_len cycles starting the cycle after tx_start.
   always @(posedge clk) begin
      if (model_en && bus.tx_start) xmit_cnt <= busy_len;
      else if (xmit_cnt > 0)        xmit_cnt <= xmit_cnt - 1;
   end
   assign bus.tx_busy = force_busy || (xmit_cnt != 0);

   // Reference arbiter: first set bit scanning upward from last+1 with wrap.
   function automatic int rr_pick(input logic [NREQ-1:0] mask, input int last);
      for (int k = 1; k <= NREQ; k++) begin
         int i;
         i = (last + k) % NREQ;
         if (mask[i]) return i;
      end
      return -1;
   endfunction

   // Waits (bounded) for any req_ready; idx stays -1 when nothing was accepted.
   task automatic wait_accept(input int bound, output int idx,
                              output logic [NREQ-1:0] vec, output int at);
      idx = -1; vec = '0; at = -1;
      for (int n = 0; n < bound; n++) begin
         #1;
         if (|bus.req_ready) begin
            vec = bus.req_ready;
            at  = cyc;
            for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) idx = i;
            return;
         end
         @(negedge clk);
      end
   endtask

   // Waits (bounded) for scheduler and transmitter both idle.
   task automatic wait_idle(input int bound, output logic ok);
      ok = 1'b0;
      for (int n = 0; n < bound; n++) begin
         #1;
         if (!bus.sched_busy && !bus.tx_busy) begin
            ok = 1'b1;
            return;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      clr = 1'b1; bus.req_valid = '0; bus.req_data = '0;
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (bus.req_ready !== 4'b0000) $display("[TB] FAIL reset_ready: got %b expected 0000", bus.req_ready); else n_pass++;
      n_checks++; if (bus.tx_start !== 1'b0) $display("[TB] FAIL reset_tx_start: got %b expected 0", bus.tx_start); else n_pass++;
      n_checks++; if (bus.tx_data !== 8'h00) $display("[TB] FAIL reset_tx_data: got %h expected 00", bus.tx_data); else n_pass++;
      n_checks++; if (bus.grant_id !== 3'd0) $display("[TB] FAIL reset_grant_id: got %0d expected 0", bus.grant_id); else n_pass++;
      n_checks++; if (bus.sched_busy !== 1'b0) $display("[TB] FAIL reset_sched_busy: got %b expected 0", bus.sched_busy); else n_pass++;
      n_checks++; if (bus.timeout_err !== 1'b0) $display("[TB] FAIL reset_timeout_err: got %b expected 0", bus.timeout_err); else n_pass++;
      clr = 1'b0;
      exp_last = NREQ - 1;
   endtask

   task automatic test_single();
      int idx, at1, at2;
      logic [NREQ-1:0] vec;
      logic ok;
      busy_len = 20;
      @(negedge clk);
      bus.req_valid = 4'b0100; bus.req_data = 32'h0041_0000;
      wait_accept(5, idx, vec, at1);
      n_checks++; if (vec !== 4'b0100) $display("[TB] FAIL single_ready: got %b expected 0100", vec); else n_pass++;
      @(negedge clk);
      bus.req_valid = 4'b0001; bus.req_data = 32'h0041_0055;
      #1;
      n_checks++; if (bus.tx_start !== 1'b1) $display("[TB] FAIL single_tx_start: got %b expected 1", bus.tx_start); else n_pass++;
      n_checks++; if (bus.tx_data !== 8'h41) $display("[TB] FAIL single_tx_data: got %h expected 41", bus.tx_data); else n_pass++;
      n_checks++; if (bus.grant_id !== 3'd2) $display("[TB] FAIL single_grant_id: got %0d expected 2", bus.grant_id); else n_pass++;
      n_checks++; if (bus.sched_busy !== 1'b1) $display("[TB] FAIL single_sched_busy: got %b expected 1", bus.sched_busy); else n_pass++;
      wait_accept(100, idx, vec, at2);
      n_checks++; if (idx !== 0) $display("[TB] FAIL single_next_idx: got %0d expected 0", idx); else n_pass++;
      n_checks++; if (at2 - at1 !== busy_len + 3) $display("[TB] FAIL single_gap: got %0d expected %0d", at2 - at1, busy_len + 3); else n_pass++;
      @(negedge clk);
      bus.req_valid = '0;
      #1;
      n_checks++; if (bus.tx_data !== 8'h55) $display("[TB] FAIL single_next_data: got %h expected 55", bus.tx_data); else n_pass++;
      wait_idle(100, ok);
      n_checks++; if (ok !== 1'b1) $display("[TB] FAIL single_idle: got %b expected 1", ok); else n_pass++;
      exp_last = 0;
   endtask

   task automatic test_fairness();
      int order [6] = '{0, 1, 2, 3, 0, 1};
      int idx, at, prev;
      logic [NREQ-1:0] vec;
      logic ok;
      @(negedge clk); clr = 1'b1;
      @(negedge clk); clr = 1'b0;
      exp_last = NREQ - 1;
      busy_len = 20;
      bus.req_valid = 4'b1111; bus.req_data = 32'h1312_1110;
      prev = 0;
      for (int r = 0; r < 6; r++) begin
         wait_accept(100, idx, vec, at);
         n_checks++; if (idx !== order[r]) $display("[TB] FAIL fair_order[%0d]: got %0d expected %0d", r, idx, order[r]); else n_pass++;
         if (r > 0) begin
            n_checks++; if (at - prev !== 23) $display("[TB] FAIL fair_gap[%0d]: got %0d expected 23", r, at - prev); else n_pass++;
         end
         prev = at;
         @(negedge clk);
         #1;
         n_checks++; if (bus.tx_data !== 8'(8'h10 + order[r])) $display("[TB] FAIL fair_data[%0d]: got %h expected %h", r, bus.tx_data, 8'(8'h10 + order[r])); else n_pass++;
      end
      bus.req_valid = '0;
      wait_idle(100, ok);
      n_checks++; if (ok !== 1'b1) $display("[TB] FAIL fair_idle: got %b expected 1", ok); else n_pass++;
      exp_last = 1;
   endtask

   task automatic test_skip_wrap();
      int order [4] = '{1, 3, 1, 3};
      int idx, at;
      logic [NREQ-1:0] vec;
      logic ok;
      @(negedge clk); clr = 1'b1;
      @(negedge clk); clr = 1'b0;
      busy_len = 3;
      bus.req_valid = 4'b1010; bus.req_data = 32'hB3A2_B1A0;
      for (int r = 0; r < 4; r++) begin
         wait_accept(50, idx, vec, at);
         n_checks++; if (vec !== NREQ'(1 << order[r])) $display("[TB] FAIL skip_ready[%0d]: got %b expected %b", r, vec, NREQ'(1 << order[r])); else n_pass++;
         @(negedge clk);
      end
      bus.req_valid = '0;
      wait_idle(50, ok);
      n_checks++; if (ok !== 1'b1) $display("[TB] FAIL skip_idle: got %b expected 1", ok); else n_pass++;
      exp_last = 3;
   endtask

   task automatic test_busy_arb();
      logic ok;
      @(negedge clk);
      force_busy = 1'b1;
      bus.req_valid = 4'b0001; bus.req_data = 32'h0000_00C4;
      for (int i = 0; i < 10; i++) begin
         #1;
         n_checks++; if (bus.req_ready !== 4'b0000) $display("[TB] FAIL busyarb_hold[%0d]: got %b expected 0000", i, bus.req_ready); else n_pass++;
         @(negedge clk);
      end
      force_busy = 1'b0;
      #1;
      n_checks++; if (bus.req_ready !== 4'b0001) $display("[TB] FAIL busyarb_accept: got %b expected 0001", bus.req_ready); else n_pass++;
      @(negedge clk);
      bus.req_valid = '0;
      wait_idle(50, ok);
      n_checks++; if (ok !== 1'b1) $display("[TB] FAIL busyarb_idle: got %b expected 1", ok); else n_pass++;
      exp_last = 0;
   endtask

   task automatic test_timeout();
      int idx, at;
      logic [NREQ-1:0] vec;
      logic ok;
      model_en = 1'b0;
      @(negedge clk);
      bus.req_valid = 4'b0010; bus.req_data = 32'h0000_7700;
      wait_accept(5, idx, vec, at);
      n_checks++; if (idx !== 1) $display("[TB] FAIL tmo_idx: got %0d expected 1", idx); else n_pass++;
      @(negedge clk);
      bus.req_valid = '0;
      #1;
      n_checks++; if (bus.tx_start !== 1'b1) $display("[TB] FAIL tmo_start: got %b expected 1", bus.tx_start); else n_pass++;
      for (int k = 1; k <= TIMEOUT; k++) begin
         @(negedge clk);
         #1;
         n_checks++; if (bus.timeout_err !== (k >= TIMEOUT)) $display("[TB] FAIL tmo_err[+%0d]: got %b expected %b", k, bus.timeout_err, k >= TIMEOUT); else n_pass++;
         n_checks++; if (bus.sched_busy !== (k < TIMEOUT)) $display("[TB] FAIL tmo_busy[+%0d]: got %b expected %b", k, bus.sched_busy, k < TIMEOUT); else n_pass++;
      end
      model_en = 1'b1;
      busy_len = 5;
      @(negedge clk);
      bus.req_valid = 4'b0100; bus.req_data = 32'h0099_0000;
      wait_accept(5, idx, vec, at);
      n_checks++; if (idx !== 2) $display("[TB] FAIL tmo_next_idx: got %0d expected 2", idx); else n_pass++;
      @(negedge clk);
      bus.req_valid = '0;
      #1;
      n_checks++; if (bus.tx_data !== 8'h99) $display("[TB] FAIL tmo_next_data: got %h expected 99", bus.tx_data); else n_pass++;
      wait_idle(50, ok);
      n_checks++; if (ok !== 1'b1) $display("[TB] FAIL tmo_idle: got %b expected 1", ok); else n_pass++;
      n_checks++; if (bus.timeout_err !== 1'b1) $display("[TB] FAIL tmo_sticky: got %b expected 1", bus.timeout_err); else n_pass++;
      @(negedge clk); clr = 1'b1;
      @(negedge clk); clr = 1'b0;
      #1;
      n_checks++; if (bus.timeout_err !== 1'b0) $display("[TB] FAIL tmo_clear: got %b expected 0", bus.timeout_err); else n_pass++;
      exp_last = NREQ - 1;
   endtask

   task automatic test_reset_midframe();
      int idx, at, s;
      logic [NREQ-1:0] vec;
      logic ok;
      busy_len = 20;
      @(negedge clk);
      bus.req_valid = 4'b0001; bus.req_data = 32'h0000_00AB;
      wait_accept(5, idx, vec, at);
      n_checks++; if (idx !== 0) $display("[TB] FAIL mid_first_idx: got %0d expected 0", idx); else n_pass++;
      @(negedge clk);
      bus.req_valid = 4'b1111; bus.req_data = 32'hD3D2_D1D0;
      #1;
      s = cyc;
      repeat (5) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      #1;
      n_checks++; if (bus.sched_busy !== 1'b0) $display("[TB] FAIL mid_idle: got %b expected 0", bus.sched_busy); else n_pass++;
      n_checks++; if (bus.req_ready !== 4'b0000) $display("[TB] FAIL mid_no_accept: got %b expected 0000", bus.req_ready); else n_pass++;
      wait_accept(100, idx, vec, at);
      n_checks++; if (idx !== 0) $display("[TB] FAIL mid_grant: got %0d expected 0", idx); else n_pass++;
      n_checks++; if (at - s !== busy_len + 1) $display("[TB] FAIL mid_accept_time: got %0d expected %0d", at - s, busy_len + 1); else n_pass++;
      @(negedge clk);
      bus.req_valid = '0;
      #1;
      n_checks++; if (bus.tx_data !== 8'hD0) $display("[TB] FAIL mid_data: got %h expected D0", bus.tx_data); else n_pass++;
      wait_idle(100, ok);
      n_checks++; if (ok !== 1'b1) $display("[TB] FAIL mid_final_idle: got %b expected 1", ok); else n_pass++;
      exp_last = 0;
   endtask

   task automatic test_random();
      int idx, at, exp;
      logic [NREQ-1:0] vec, mask;
      logic [31:0] dvec;
      logic ok;
      for (int r = 0; r < 12; r++) begin
         mask     = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         dvec     = $urandom();
         busy_len = $urandom_range(1, 8);
         exp      = rr_pick(mask, exp_last);
         @(negedge clk);
         bus.req_valid = mask; bus.req_data = dvec;
         wait_accept(50, idx, vec, at);
         n_checks++; if (vec !== NREQ'(1 << exp)) $display("[TB] FAIL rand_ready[%0d]: got %b expected %b (mask %b)", r, vec, NREQ'(1 << exp), mask); else n_pass++;
         @(negedge clk);
         bus.req_valid = '0;
         #1;
         n_checks++; if (bus.tx_data !== dvec[8*exp +: 8]) $display("[TB] FAIL rand_data[%0d]: got %h expected %h", r, bus.tx_data, dvec[8*exp +: 8]); else n_pass++;
         n_checks++; if (bus.grant_id !== 3'(exp)) $display("[TB] FAIL rand_grant[%0d]: got %0d expected %0d", r, bus.grant_id, exp); else n_pass++;
         exp_last = exp;
         wait_idle(50, ok);
         n_checks++; if (ok !== 1'b1) $display("[TB] FAIL rand_idle[%0d]: got %b expected 1", r, ok); else n_pass++;
      end
   endtask

   initial begin
      bus.req_valid = '0;
      bus.req_data  = '0;
      $display("[TB] starting uart_tx_sched bench");
      test_reset();
      test_single();
      test_fairness();
      test_skip_wrap();
      test_busy_arb();
      test_timeout();
      test_reset_midframe();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end
endmodule
